// File: rtl/delay_input_conditioner.sv
// Front-end for the blinking-LED path: synchronises and debounces KEY1 and the
// delay switches, then emits a one-cycle update strobe with a registered delay.
module delay_input_conditioner #(
  parameter int TICKS_PER_MS = 50000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int WIDTH        = 14
) (
  input  logic             clk,
  input  logic             KEY0,
  input  logic             KEY1,
  input  logic [WIDTH-1:0] switches,
  output logic             update,
  output logic [WIDTH-1:0] delay,
  output logic             key_held
);
  localparam int N  = DEBOUNCE_MS * TICKS_PER_MS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW-1:0] NM1_C = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [1:0]            key_pipe;
  logic [1:0][WIDTH-1:0] sw_pipe;
  logic                  key_s;
  logic [WIDTH-1:0]      sw_s;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  upd_nxt;

  logic [WIDTH-1:0]      sw_prev, sw_stable;
  logic [CW-1:0]         sw_cnt;

  assign key_s = key_pipe[1];
  assign sw_s  = sw_pipe[1];

  // Two-flop synchronisers; key idles released (1) so a held key is seen as a new press
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      key_pipe <= 2'b11;
      sw_pipe  <= '0;
    end else begin
      key_pipe <= {key_pipe[0], KEY1};
      sw_pipe  <= {sw_pipe[0], switches};
    end
  end

  // Key FSM state, counter and the registered update strobe
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      state  <= IDLE;
      cnt    <= '0;
      update <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      update <= upd_nxt;
    end
  end

  // Next-state: counter holds cycles already debounced, so hitting N-1 means this edge is the Nth
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    upd_nxt   = 1'b0;
    case (state)
      IDLE: if (!key_s) begin
        state_nxt = PRESS_WAIT;
        cnt_nxt   = '0;
      end
      PRESS_WAIT: begin
        if (key_s) state_nxt = IDLE;
        else if (cnt == NM1_C) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          upd_nxt   = 1'b1;
        end else cnt_nxt = cnt + CW'(1);
      end
      HELD: if (key_s) begin
        state_nxt = RELEASE_WAIT;
        cnt_nxt   = '0;
      end
      RELEASE_WAIT: begin
        if (!key_s) state_nxt = HELD;
        else if (cnt == NM1_C) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign key_held = (state == HELD) || (state == RELEASE_WAIT);

  // Switch filter: any change restarts the count; once saturated the vector is accepted
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      sw_prev   <= '0;
      sw_cnt    <= '0;
      sw_stable <= WIDTH'(1);
    end else begin
      sw_prev <= sw_s;
      if (sw_s != sw_prev)  sw_cnt    <= '0;
      else if (sw_cnt != N_C) sw_cnt  <= sw_cnt + CW'(1);
      else                  sw_stable <= sw_s;
    end
  end

  // Delay loads alongside the strobe, using the stable vector from before this edge; 0 clamps to 1
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0)        delay <= WIDTH'(1);
    else if (upd_nxt) delay <= (sw_stable == '0) ? WIDTH'(1) : sw_stable;
  end
endmodule

// File: doc/delay_input_conditioner.md
# delay_input_conditioner

Front-end stage for the blinking-LED path. It synchronises and debounces the KEY1 push-button and the 14 delay switches, and presents a clean one-cycle `update` strobe plus a registered, range-checked `delay` word to the LED timing stage. The downstream stage loads `delay` on `update`, so it no longer needs its own edge detector or raw-switch sampling.

## Interface

Parameters:
- `TICKS_PER_MS`, default 50000: clock cycles per millisecond (50 MHz clock).
- `DEBOUNCE_MS`, default 10: milliseconds an input must stay stable to be accepted; legal range ≥1.
- `WIDTH`, default 14: switch and delay width.

Ports:
- `clk`  input  1: system clock. One clock domain.
- `KEY0`  input  1: asynchronous, active-low reset.
- `KEY1`  input  1: raw push-button, active-low (0 = pressed), asynchronous to `clk`.
- `switches`  input  WIDTH: raw slide switches, asynchronous to `clk`.
- `update`  output  1: one-cycle strobe on each debounced press.
- `delay`  output  WIDTH: delay value, valid whenever `update` is high, held otherwise.
- `key_held`  output  1: debounced button level (1 = pressed).

## Operation

- **Synchronisers:** 2-FF synchroniser on `KEY1` (reset value 1, released) and on each `switches` bit (reset value 0). All logic below uses the synchronised values only.
- **Key FSM** (`IDLE`, `PRESS_WAIT`, `HELD`, `RELEASE_WAIT`), with its own tick counter of width clog2(DEBOUNCE_MS·TICKS_PER_MS+1):
  - `IDLE`: synchronised key = 0 → `PRESS_WAIT`, counter cleared.
  - `PRESS_WAIT`: key = 1 → `IDLE` (bounce rejected). Otherwise the counter increments. When it reaches N = DEBOUNCE_MS·TICKS_PER_MS → `HELD`, and `update` pulses.
  - `HELD`: key = 1 → `RELEASE_WAIT`, counter cleared.
  - `RELEASE_WAIT`: key = 0 → `HELD` with no new `update`. Otherwise count; at N → `IDLE`.
- **Switch filter:** `sw_prev` is the synchronised vector delayed one cycle. Any bit difference clears the stable counter. When the counter reaches N, the synchronised vector is copied into `sw_stable` and the counter saturates. `sw_stable` resets to 1.
- **Delay register:** on the edge where `update` is raised, `delay` loads `sw_stable`. A value of 0 is clamped to 1. `delay` is unchanged at all other times.
- `key_held` = 1 in `HELD` and `RELEASE_WAIT`, 0 otherwise.

## Timing

- **Reset values:** `update` = 0, `delay` = 1, `key_held` = 0, FSM in `IDLE`, all counters 0. Reset is asynchronous: assertion mid-debounce aborts immediately, and `update` drops in the same cycle without waiting for a clock edge.
- **Press latency:** let edge 0 be the first edge at which the first sync FF captures 0. The FSM enters `PRESS_WAIT` at edge 2. `update` is high for exactly the cycle after edge 2+N, and `delay` is valid in that same cycle.
- **Bounce:** any 1 during `PRESS_WAIT` restarts the full N count on the next low.
- **Single strobe:** exactly one `update` per accepted press, regardless of hold length. Release bounces shorter than N produce no second strobe.
- **Switch latency:** a switch change becomes eligible for `delay` 2+N+1 cycles after capture, provided there are no further changes in that window.
- **Simultaneous switch change and press confirmation:** `delay` takes the previous `sw_stable`.
- **Key held through reset release:** the sync FFs start at 1, so a held key produces one `update` after 2+N cycles.

## Test plan

All scenarios use TICKS_PER_MS=4, DEBOUNCE_MS=3, so N=12.

- **Reset check:** assert `KEY0`=0 mid-`PRESS_WAIT` → `update`=0 and `key_held`=0 immediately; `delay`=1.
- **Clean press:** switches=100 stable for 20 cycles, then `KEY1` low for 40 cycles → single `update` in the cycle after edge 14, `delay`=100, `key_held`=1 until 12 cycles after a stable release.
- **Press bounce:** `KEY1` low 5 cycles, high 2, low 30 → no `update` for the first burst; `update` 14 cycles after the final low is captured.
- **Release bounce:** while `HELD`, toggle `KEY1` high/low every 3 cycles for 30 cycles → no extra `update`, `key_held` stays 1.
- **Zero clamp:** switches=0 stable, then press → `delay`=1.
- **Late switch change:** switches change 100→200 four cycles before press confirmation → `delay`=100. The next press after 20 stable cycles gives `delay`=200.
